// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised raster timing generator with a built-in test-pattern source.
// Horizontal and vertical counters step on every clk edge that has pix_en=1.
// All outputs are registered from the current counter position. Each output
// therefore reflects position (h,v) one enabled cycle after the counters
// held (h,v).
//
// Line order (both axes): active, front porch, sync, back porch.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-low reset
//   pix_en       pixel-rate enable; nothing advances while it is 0
//   mode_sel     pattern select (00 solid, 01 bars, 10 checker, 11 gradient),
//                taken only on the enabled cycle at h=0,v=0
//   fg_color     {R,G,B} colour for the solid and checker patterns
//   hsync/vsync  sync outputs, active level set by H_POL / V_POL
//   de           data enable, 1 inside the active area
//   x, y         active-area coordinates, 0 outside the active area
//   red/green/blue  pixel colour, 0 while de=0
//   line_start   one-cycle pulse for the output cycle of h=0
//   frame_start  one-cycle pulse for the output cycle of h=0,v=0
//   frame_cnt    (only with VGA_FRAME_COUNT_EN) 16-bit count of frame_start
//                output cycles; wraps from 0xFFFF to 0
//
// Optional feature macro: VGA_FRAME_COUNT_EN
// CW must be at least 8 and must be larger than CHK_LOG2.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int CW       = 12,
    parameter int CHK_LOG2 = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    input  logic [1:0]    mode_sel,
    input  logic [23:0]   fg_color,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic [7:0]    red,
    output logic [7:0]    green,
    output logic [7:0]    blue,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [15:0]   frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE >> 3;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] BAR_LAST = CW'(BAR_W - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic          HS_ACT   = (H_POL != 0);
    localparam logic          VS_ACT   = (V_POL != 0);

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic [CW-1:0] bar_px;   // pixel position inside the current bar
    logic [2:0]    bar_idx;  // bar index for the current h_cnt, saturates at 7
    logic [1:0]    mode_q;

    logic          h_wrap;
    logic          v_wrap;
    logic          at_origin;
    logic [1:0]    mode_eff;
    logic          de_c;
    logic          hs_c;
    logic          vs_c;
    logic [23:0]   bar_rgb;
    logic [23:0]   rgb_c;

    assign h_wrap    = (h_cnt == H_LAST);
    assign v_wrap    = (v_cnt == V_LAST);
    assign at_origin = (h_cnt == '0) && (v_cnt == '0);
    // The frame's first pixel already uses the newly selected mode.
    assign mode_eff  = at_origin ? mode_sel : mode_q;
    assign de_c      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_c      = ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? HS_ACT : ~HS_ACT;
    assign vs_c      = ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? VS_ACT : ~VS_ACT;

    // Position counters, bar tracking and frame-locked mode register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            bar_px  <= '0;
            bar_idx <= 3'd0;
            mode_q  <= 2'b00;
        end else if (pix_en) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + CNT_ONE;
            end else begin
                h_cnt <= h_cnt + CNT_ONE;
            end

            // Bar index follows h_cnt without a divider: a pixel counter
            // rolls every BAR_W pixels and bumps the index.
            if (h_wrap) begin
                bar_px  <= '0;
                bar_idx <= 3'd0;
            end else if (bar_px == BAR_LAST) begin
                bar_px <= '0;
                if (bar_idx != 3'd7) begin
                    bar_idx <= bar_idx + 3'd1;
                end
            end else begin
                bar_px <= bar_px + CNT_ONE;
            end

            if (at_origin) begin
                mode_q <= mode_sel;
            end
        end
    end

    always_comb begin
        bar_rgb = 24'h000000;
        case (bar_idx)
            3'd0:    bar_rgb = 24'hFFFFFF;  // white
            3'd1:    bar_rgb = 24'hFFFF00;  // yellow
            3'd2:    bar_rgb = 24'h00FFFF;  // cyan
            3'd3:    bar_rgb = 24'h00FF00;  // green
            3'd4:    bar_rgb = 24'hFF00FF;  // magenta
            3'd5:    bar_rgb = 24'hFF0000;  // red
            3'd6:    bar_rgb = 24'h0000FF;  // blue
            default: bar_rgb = 24'h000000;  // black, also leftover pixels
        endcase
    end

    always_comb begin
        rgb_c = 24'h000000;
        if (de_c) begin
            case (mode_eff)
                2'b00:   rgb_c = fg_color;
                2'b01:   rgb_c = bar_rgb;
                2'b10:   rgb_c = (h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2]) ? 24'h000000 : fg_color;
                default: rgb_c = {3{h_cnt[7:0]}};
            endcase
        end
    end

    // Output register: every output takes the same single enabled cycle of
    // latency. During a stall the strobes drop and everything else holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync       <= ~HS_ACT;
            vsync       <= ~VS_ACT;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            red         <= 8'd0;
            green       <= 8'd0;
            blue        <= 8'd0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            hsync       <= hs_c;
            vsync       <= vs_c;
            de          <= de_c;
            x           <= de_c ? h_cnt : '0;
            y           <= de_c ? v_cnt : '0;
            red         <= rgb_c[23:16];
            green       <= rgb_c[15:8];
            blue        <= rgb_c[7:0];
            line_start  <= (h_cnt == '0);
            frame_start <= at_origin;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    // Counts in step with the frame_start output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt <= 16'd0;
        end else if (pix_en && at_origin) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two instances: a small-timing one (H 8/2/3/1, V 4/1/1/1, CHK_LOG2=1) for
// whole-frame behaviour and a default 640x480 one for the pattern colours.
// A reference model computes each expected output word from the raster
// position with plain arithmetic; expected words pass through exp_q.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s, pen_s, rst_b, pen_b;
    logic [1:0]  mode_s, mode_b;
    logic [23:0] fg_s, fg_b;

    logic        hs_s, vs_s, de_s, ls_s, fs_s;
    logic [11:0] x_s, y_s;
    logic [7:0]  r_s, g_s, b_s;
    logic        hs_b, vs_b, de_b, ls_b, fs_b;
    logic [11:0] x_b, y_b;
    logic [7:0]  r_b, g_b, b_b;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] fc_s, fc_b;
`endif

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CHK_LOG2(1)
    ) dut_s (
        .clk(clk), .rst(rst_s), .pix_en(pen_s), .mode_sel(mode_s), .fg_color(fg_s),
        .hsync(hs_s), .vsync(vs_s), .de(de_s), .x(x_s), .y(y_s),
        .red(r_s), .green(g_s), .blue(b_s),
        .line_start(ls_s), .frame_start(fs_s)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_cnt(fc_s)
`endif
    );

    vga_timing_gen dut_b (
        .clk(clk), .rst(rst_b), .pix_en(pen_b), .mode_sel(mode_b), .fg_color(fg_b),
        .hsync(hs_b), .vsync(vs_b), .de(de_b), .x(x_b), .y(y_b),
        .red(r_b), .green(g_b), .blue(b_b),
        .line_start(ls_b), .frame_start(fs_b)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_cnt(fc_b)
`endif
    );

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Output word: {hsync, vsync, de, x[11:0], y[11:0], rgb[23:0], line_start, frame_start}
    localparam logic [52:0] RST_VAL = {2'b11, 51'd0};

    int c_ha[2]  = '{8, 640};
    int c_hf[2]  = '{2, 16};
    int c_hs[2]  = '{3, 96};
    int c_hb[2]  = '{1, 48};
    int c_va[2]  = '{4, 480};
    int c_vf[2]  = '{1, 10};
    int c_vs[2]  = '{1, 2};
    int c_vb[2]  = '{1, 33};
    int c_chk[2] = '{1, 5};

    int          m_h[2];
    int          m_v[2];
    logic [1:0]  m_mode[2];
    logic [52:0] m_last[2];
    logic [15:0] m_fc[2];
    logic [52:0] exp_q[$];

    function automatic logic [52:0] expect_px(input int s, input int h, input int v,
                                              input logic [1:0] md, input logic [23:0] fg);
        logic [23:0] bars[8];
        int          hs0, vs0, idx;
        logic        hs, vs, de;
        logic [11:0] x, y;
        logic [23:0] rgb;
        logic [7:0]  g8;
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        hs0 = c_ha[s] + c_hf[s];
        vs0 = c_va[s] + c_vf[s];
        hs  = !((h >= hs0) && (h < hs0 + c_hs[s]));
        vs  = !((v >= vs0) && (v < vs0 + c_vs[s]));
        de  = (h < c_ha[s]) && (v < c_va[s]);
        x   = de ? 12'(h) : 12'd0;
        y   = de ? 12'(v) : 12'd0;
        rgb = 24'd0;
        if (de) begin
            case (md)
                2'b00: rgb = fg;
                2'b01: begin
                    idx = h / (c_ha[s] / 8);
                    if (idx > 7) idx = 7;
                    rgb = bars[idx];
                end
                2'b10: rgb = ((((h >> c_chk[s]) ^ (v >> c_chk[s])) & 1) != 0) ? 24'd0 : fg;
                default: begin
                    g8  = 8'(h % 256);
                    rgb = {g8, g8, g8};
                end
            endcase
        end
        return {hs, vs, de, x, y, rgb, (h == 0), (h == 0 && v == 0)};
    endfunction

    function automatic logic [52:0] obs(input int s);
        if (s == 0) return {hs_s, vs_s, de_s, x_s, y_s, r_s, g_s, b_s, ls_s, fs_s};
        return {hs_b, vs_b, de_b, x_b, y_b, r_b, g_b, b_b, ls_b, fs_b};
    endfunction

    task automatic model_reset(input int s);
        m_h[s]    = 0;
        m_v[s]    = 0;
        m_mode[s] = 2'b00;
        m_last[s] = RST_VAL;
        m_fc[s]   = 16'd0;
    endtask

    // ---------------- driver ----------------
    task automatic step(input int s, input logic pen, input logic [1:0] md, input logic [23:0] fg);
        logic [52:0] e;
        @(negedge clk);
        if (s == 0) begin
            pen_s = pen; mode_s = md; fg_s = fg;
        end else begin
            pen_b = pen; mode_b = md; fg_b = fg;
        end
        if (pen) begin
            if (m_h[s] == 0 && m_v[s] == 0) m_mode[s] = md;
            e = expect_px(s, m_h[s], m_v[s], m_mode[s], fg);
            if (e[0]) m_fc[s] = m_fc[s] + 16'd1;
            m_h[s] = m_h[s] + 1;
            if (m_h[s] == c_ha[s] + c_hf[s] + c_hs[s] + c_hb[s]) begin
                m_h[s] = 0;
                m_v[s] = m_v[s] + 1;
                if (m_v[s] == c_va[s] + c_vf[s] + c_vs[s] + c_vb[s]) m_v[s] = 0;
            end
        end else begin
            e = {m_last[s][52:2], 2'b00};
        end
        m_last[s] = e;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check((s == 0) ? "pix_s" : "pix_b", 64'(obs(s)), 64'(exp_q.pop_front()));
`ifdef VGA_FRAME_COUNT_EN
        check((s == 0) ? "frame_cnt_s" : "frame_cnt_b", 64'((s == 0) ? fc_s : fc_b), 64'(m_fc[s]));
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          hl, vl, fsn, lsn, seen, en, lsw, bad;
        logic        pen;
        logic [23:0] fg;

        rst_s = 1'b0; rst_b = 1'b0;
        pen_s = 1'b1; pen_b = 1'b1;
        mode_s = 2'b00; mode_b = 2'b00;
        fg_s = 24'd0; fg_b = 24'd0;
        model_reset(0);
        model_reset(1);

        // Reset held with pix_en=1: outputs sit at reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst_s", 64'(obs(0)), 64'(RST_VAL));
        check("rst_b", 64'(obs(1)), 64'(RST_VAL));
        @(negedge clk);
        pen_s = 1'b0;
        rst_s = 1'b1;

        // One full small frame at pix_en=1.
        fg = 24'($urandom);
        hl = 0; vl = 0; fsn = 0; lsn = 0;
        for (int i = 0; i < 98; i++) begin
            step(0, 1'b1, 2'b00, fg);
            if (i == 0) begin
                check("first_frame_start", 64'(fs_s), 64'(1));
                check("first_line_start", 64'(ls_s), 64'(1));
            end
            hl  += (hs_s == 1'b0) ? 1 : 0;
            vl  += (vs_s == 1'b0) ? 1 : 0;
            fsn += fs_s ? 1 : 0;
            lsn += ls_s ? 1 : 0;
        end
        check("hsync_low_cycles", 64'(hl), 64'(21));
        check("vsync_low_cycles", 64'(vl), 64'(14));
        check("frame_starts_per_frame", 64'(fsn), 64'(1));
        check("line_starts_per_frame", 64'(lsn), 64'(7));

        // Stall pattern 1,0,0,1 then random pix_en; frame length in enabled cycles.
        step(0, 1'b1, 2'b00, fg);
        step(0, 1'b0, 2'b00, fg);
        step(0, 1'b0, 2'b00, fg);
        step(0, 1'b1, 2'b00, fg);
        seen = 0; en = 0; lsw = 0;
        for (int i = 0; i < 2000 && seen < 2; i++) begin
            pen = ($urandom_range(0, 2) != 0);
            step(0, pen, 2'b00, 24'($urandom));
            if (fs_s) seen++;
            if (seen == 1 && pen) begin
                en++;
                if (ls_s) lsw++;
            end
        end
        check("stall_frames_seen", 64'(seen), 64'(2));
        check("stall_frame_enabled_len", 64'(en), 64'(98));
        check("stall_line_starts", 64'(lsw), 64'(7));

        // mode_sel 00 -> 01 at v=2: current frame stays solid.
        fg = 24'($urandom);
        for (int i = 0; i < 200 && m_v[0] != 2; i++) step(0, 1'b1, 2'b00, fg);
        bad = 0; seen = 0;
        for (int i = 0; i < 200; i++) begin
            step(0, 1'b1, 2'b01, fg);
            if (fs_s) begin
                seen = 1;
                break;
            end
            if (de_s && {r_s, g_s, b_s} != fg) bad++;
        end
        check("old_frame_solid", 64'(bad), 64'(0));
        check("new_frame_seen", 64'(seen), 64'(1));
        check("new_frame_bar0", 64'({r_s, g_s, b_s}), 64'(24'hFFFFFF));
        for (int i = 0; i < 100; i++) step(0, 1'b1, 2'b01, fg);

        // Random checker / gradient / random-mode frames.
        for (int i = 0; i < 250; i++) step(0, ($urandom_range(0, 3) != 0), 2'b10, 24'($urandom));
        for (int i = 0; i < 250; i++) step(0, ($urandom_range(0, 3) != 0), 2'b11, 24'($urandom));
        for (int i = 0; i < 400; i++)
            step(0, ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 24'($urandom));

        // Mid-frame reset restarts at (0,0).
        for (int i = 0; i < 200 && m_v[0] != 2; i++) step(0, 1'b1, 2'b10, fg);
        @(negedge clk);
        rst_s = 1'b0;
        pen_s = 1'b0;
        #1;
        check("midframe_rst_s", 64'(obs(0)), 64'(RST_VAL));
        model_reset(0);
        @(negedge clk);
        rst_s = 1'b1;
        step(0, 1'b1, 2'b00, fg);
        check("restart_frame_start", 64'(fs_s), 64'(1));
        for (int i = 0; i < 120; i++) step(0, ($urandom_range(0, 3) != 0), 2'b00, fg);

        // Default 640x480 instance: colour bars on the first line.
        @(negedge clk);
        pen_b = 1'b0;
        rst_b = 1'b1;
        fg = 24'($urandom);
        for (int i = 0; i < 800; i++) begin
            step(1, 1'b1, 2'b01, fg);
            if (i == 0)   check("bar_x0_white",    64'({r_b, g_b, b_b}), 64'(24'hFFFFFF));
            if (i == 79)  check("bar_x79_white",   64'({r_b, g_b, b_b}), 64'(24'hFFFFFF));
            if (i == 80)  check("bar_x80_yellow",  64'({r_b, g_b, b_b}), 64'(24'hFFFF00));
            if (i == 560) check("bar_x560_black",  64'({r_b, g_b, b_b}), 64'(24'h000000));
            if (i == 639) check("bar_x639_black",  64'({r_b, g_b, b_b}), 64'(24'h000000));
        end

        // Reset mid-line, then gradient.
        @(negedge clk);
        rst_b = 1'b0;
        pen_b = 1'b0;
        #1;
        check("midline_rst_b", 64'(obs(1)), 64'(RST_VAL));
        model_reset(1);
        @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < 301; i++) begin
            step(1, 1'b1, 2'b11, fg);
            if (i == 300) begin
                check("grad_x300_x", 64'(x_b), 64'(300));
                check("grad_x300_rgb", 64'({r_b, g_b, b_b}), 64'(24'h2C2C2C));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
